// File: rtl/mem_access_unit_if.sv
// Request/response and RAM-side signals of the load/store unit.
// The master side is the controller plus the RAM; the slave side is the unit itself.
interface mem_access_unit_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_misaligned;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_misaligned,
           mem_addr, mem_we, mem_wdata
  );

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_misaligned,
           mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit for a single-port word RAM with one-cycle read latency:
// alignment check, load extension and read-modify-write for sub-word stores.
module mem_access_unit #(
  parameter int ADDR_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  mem_access_unit_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, READ, RWAIT, WRITE, RESP, ERR} state_t;

  state_t            state, state_next;
  logic              write_q;
  logic [2:0]        funct3_q;
  logic [1:0]        offset_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic [31:0]       resp_rdata_q;
  logic              req_legal;
  logic              req_aligned;

  function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] off,
                                          input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return word;
    endcase
  endfunction

  // Sub-word stores overwrite only their lane(s); a word store replaces everything.
  function automatic logic [31:0] merge(input logic [2:0] f3, input logic [1:0] off,
                                        input logic [31:0] old, input logic [31:0] wd);
    logic [31:0] r;
    r = old;
    case (f3[1:0])
      2'b00:   r[{off, 3'b000} +: 8]    = wd[7:0];
      2'b01:   r[{off[1], 4'b0000} +: 16] = wd[15:0];
      default: r = wd;
    endcase
    return r;
  endfunction

  // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    req_legal   = 1'b0;
    req_aligned = 1'b1;
    if (bus.req_write) req_legal = bus.req_funct3 inside {3'b000, 3'b001, 3'b010};
    else               req_legal = bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    case (bus.req_funct3[1:0])
      2'b01:   req_aligned = ~bus.req_addr[0];
      2'b10:   req_aligned = (bus.req_addr[1:0] == 2'b00);
      default: req_aligned = 1'b1;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (!req_legal || !req_aligned)                state_next = ERR;
          else if (bus.req_write && bus.req_funct3 == 3'b010) state_next = WRITE;
          else                                           state_next = READ;
        end
      end
      READ:    state_next = RWAIT;
      RWAIT:   state_next = write_q ? WRITE : RESP;
      WRITE:   state_next = RESP;
      RESP:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_q      <= 1'b0;
      funct3_q     <= 3'b000;
      offset_q     <= 2'b00;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 32'h0;
      resp_rdata_q <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            write_q      <= bus.req_write;
            funct3_q     <= bus.req_funct3;
            offset_q     <= bus.req_addr[1:0];
            resp_rdata_q <= 32'h0;
            // Rejected requests never touch the RAM, so its address bus keeps its last value.
            if (state_next != ERR) begin
              mem_addr_q  <= {bus.req_addr[ADDR_W-1:2], 2'b00};
              mem_wdata_q <= bus.req_wdata;
            end
          end
        end
        RWAIT: begin
          if (write_q) mem_wdata_q  <= merge(funct3_q, offset_q, bus.mem_rdata, mem_wdata_q);
          else         resp_rdata_q <= extract(funct3_q, offset_q, bus.mem_rdata);
        end
        default: ;
      endcase
    end
  end

  // Decoding the write strobe from state alone lets reset drop it without waiting for an edge.
  assign bus.req_ready       = (state == IDLE);
  assign bus.mem_we          = (state == WRITE);
  assign bus.resp_valid      = (state == RESP) || (state == ERR);
  assign bus.resp_misaligned = (state == ERR);
  assign bus.resp_rdata      = resp_rdata_q;
  assign bus.mem_addr        = mem_addr_q;
  assign bus.mem_wdata       = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vectors, multi-cycle corner
// sequences and random requests against a byte-lane reference model.
module tb_mem_access_unit;

  logic clk;
  logic reset;
  logic preload;
  int   checks;
  int   failures;

  mem_access_unit_if #(.ADDR_W(32)) bus ();

  mem_access_unit #(.ADDR_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  logic [31:0] init_mem [0:255];
  logic [31:0] ram      [0:255];
  logic [31:0] ref_mem  [0:255];

  // Synchronous word RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_mem[i];
    end else if (bus.mem_we) begin
      ram[bus.mem_addr[9:2]] <= bus.mem_wdata;
    end
    bus.mem_rdata <= ram[bus.mem_addr[9:2]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: byte-lane arithmetic over a word array.
  function automatic void model(input logic w, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, output logic [31:0] rd,
                                output logic mis, output int lat, output int we_cnt,
                                output logic [31:0] we_word);
    int size;
    int sh;
    bit legal;
    longint unsigned word, mask, val;
    legal   = w ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size    = 1 << f3[1:0];
    rd      = 32'h0;
    mis     = 1'b0;
    we_cnt  = 0;
    we_word = 32'h0;
    if (!legal || (a % size) != 0) begin
      mis = 1'b1;
      lat = 1;
      return;
    end
    sh   = 8 * int'(a % 4);
    word = longint'(ref_mem[a[9:2]]);
    mask = (64'd1 << (8 * size)) - 64'd1;
    if (w) begin
      val = (word & ~(mask << sh)) | ((longint'(wd) & mask) << sh);
      ref_mem[a[9:2]] = val[31:0];
      we_cnt  = 1;
      we_word = val[31:0];
      lat     = (size == 4) ? 2 : 4;
    end else begin
      val = (word >> sh) & mask;
      if (!f3[2] && size < 4 && val >= (mask + 64'd1) / 2) val = val - (mask + 64'd1);
      rd  = val[31:0];
      lat = 3;
    end
  endfunction

  task automatic wait_accept();
    int n;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", {31'h0, bus.req_ready}, 32'h1);
    @(posedge clk);
  endtask

  // Counts cycles after the accept edge until resp_valid, tracking RAM writes.
  task automatic wait_resp(output logic [31:0] rd, output logic mis, output int lat,
                           output int we_cnt, output logic [31:0] we_data,
                           output logic [31:0] we_addr);
    rd = 32'h0; mis = 1'b0; lat = 0; we_cnt = 0; we_data = 32'h0; we_addr = 32'h0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) bus.req_valid = 1'b0;
      if (bus.mem_we) begin
        we_cnt++;
        we_data = bus.mem_wdata;
        we_addr = bus.mem_addr;
      end
      if (bus.resp_valid) begin
        rd  = bus.resp_rdata;
        mis = bus.resp_misaligned;
        lat = c;
        break;
      end
    end
  endtask

  task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output logic mis,
                        output int lat, output int we_cnt, output logic [31:0] we_data,
                        output logic [31:0] we_addr);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = w;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    wait_accept();
    wait_resp(rd, mis, lat, we_cnt, we_data, we_addr);
    @(negedge clk);
    check("resp_single_pulse", {31'h0, bus.resp_valid}, 32'h0);
  endtask

  typedef struct {
    logic        w;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_mis;
    int          exp_lat;
    int          exp_we;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs [11];

  initial begin
    logic [31:0] rd, we_data, we_addr, m_rd, m_word, wd;
    logic        mis, m_mis;
    int          lat, we_cnt, m_lat, m_we, resp_c, ready_c;
    logic        w;
    logic [2:0]  f3;
    logic [31:0] a;

    clk = 1'b0; reset = 1'b1; preload = 1'b1; checks = 0; failures = 0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    for (int i = 0; i < 256; i++) init_mem[i] = $urandom;
    init_mem[8'h40] = 32'h8899AABB;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_mem[i];

    vecs[0]  = '{1'b0, 3'b010, 32'h100, 32'h0, 32'h8899AABB, 1'b0, 3, 0, 32'h0};
    vecs[1]  = '{1'b0, 3'b000, 32'h103, 32'h0, 32'hFFFFFF88, 1'b0, 3, 0, 32'h0};
    vecs[2]  = '{1'b0, 3'b100, 32'h103, 32'h0, 32'h00000088, 1'b0, 3, 0, 32'h0};
    vecs[3]  = '{1'b0, 3'b001, 32'h102, 32'h0, 32'hFFFF8899, 1'b0, 3, 0, 32'h0};
    vecs[4]  = '{1'b0, 3'b101, 32'h100, 32'h0, 32'h0000AABB, 1'b0, 3, 0, 32'h0};
    vecs[5]  = '{1'b1, 3'b001, 32'h101, 32'hDEADBEEF, 32'h0, 1'b1, 1, 0, 32'h0};
    vecs[6]  = '{1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0};
    vecs[7]  = '{1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0};
    vecs[8]  = '{1'b1, 3'b100, 32'h100, 32'h11111111, 32'h0, 1'b1, 1, 0, 32'h0};
    vecs[9]  = '{1'b1, 3'b000, 32'h101, 32'h12345677, 32'h0, 1'b0, 4, 1, 32'h889977BB};
    vecs[10] = '{1'b0, 3'b010, 32'h100, 32'h0, 32'h889977BB, 1'b0, 3, 0, 32'h0};

    repeat (2) @(negedge clk);
    preload = 1'b0;
    check("rst_req_ready", {31'h0, bus.req_ready}, 32'h1);
    check("rst_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
    check("rst_resp_misaligned", {31'h0, bus.resp_misaligned}, 32'h0);
    check("rst_resp_rdata", bus.resp_rdata, 32'h0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_mem_we", {31'h0, bus.mem_we}, 32'h0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      do_req(vecs[i].w, vecs[i].f3, vecs[i].addr, vecs[i].wd, rd, mis, lat, we_cnt,
             we_data, we_addr);
      model(vecs[i].w, vecs[i].f3, vecs[i].addr, vecs[i].wd, m_rd, m_mis, m_lat, m_we, m_word);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d_misaligned", i), {31'h0, mis}, {31'h0, vecs[i].exp_mis});
      check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("vec%0d_we_cycles", i), we_cnt, vecs[i].exp_we);
      if (vecs[i].exp_we != 0) begin
        check($sformatf("vec%0d_mem_wdata", i), we_data, vecs[i].exp_wdata);
        check($sformatf("vec%0d_mem_addr", i), we_addr, {vecs[i].addr[31:2], 2'b00});
      end
    end

    // Reset while the sb write strobe is high: the write must never land.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h100; bus.req_wdata = 32'h00000055;
    wait_accept();
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      if (bus.mem_we) break;
    end
    check("rst_seq_reached_write", {31'h0, bus.mem_we}, 32'h1);
    #1 reset = 1'b1;
    #1;
    check("rst_mid_mem_we", {31'h0, bus.mem_we}, 32'h0);
    check("rst_mid_req_ready", {31'h0, bus.req_ready}, 32'h1);
    check("rst_mid_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("rst_no_resp", {31'h0, bus.resp_valid}, 32'h0);
    end
    do_req(1'b0, 3'b010, 32'h100, 32'h0, rd, mis, lat, we_cnt, we_data, we_addr);
    check("rst_ram_unchanged", rd, ref_mem[8'h40]);

    // Back-to-back with req_valid held high: second accept only after RESP.
    wd = $urandom;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_funct3 = 3'b010;
    bus.req_addr = 32'h104; bus.req_wdata = wd;
    wait_accept();
    model(1'b1, 3'b010, 32'h104, wd, m_rd, m_mis, m_lat, m_we, m_word);
    resp_c = 0; ready_c = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.req_write = 1'b0; bus.req_addr = 32'h104; bus.req_wdata = 32'h0;
      end
      if (bus.resp_valid && resp_c == 0) resp_c = c;
      if (bus.req_ready) begin
        ready_c = c;
        break;
      end
    end
    check("b2b_sw_resp_cycle", resp_c, 2);
    check("b2b_accept_cycle", ready_c, 3);
    @(posedge clk);
    wait_resp(rd, mis, lat, we_cnt, we_data, we_addr);
    check("b2b_lw_latency", lat, 3);
    check("b2b_lw_rdata", rd, wd);
    check("b2b_lw_misaligned", {31'h0, mis}, 32'h0);

    // Random requests over a small address window, so loads see earlier stores.
    for (int i = 0; i < 60; i++) begin
      w  = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = 32'h100 + 32'($urandom_range(0, 31));
      wd = $urandom;
      do_req(w, f3, a, wd, rd, mis, lat, we_cnt, we_data, we_addr);
      model(w, f3, a, wd, m_rd, m_mis, m_lat, m_we, m_word);
      check($sformatf("rnd%0d_rdata", i), rd, m_rd);
      check($sformatf("rnd%0d_misaligned", i), {31'h0, mis}, {31'h0, m_mis});
      check($sformatf("rnd%0d_latency", i), lat, m_lat);
      check($sformatf("rnd%0d_we_cycles", i), we_cnt, m_we);
      if (m_we != 0) check($sformatf("rnd%0d_mem_wdata", i), we_data, m_word);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "simulation watchdog expired");
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Load/store unit between the multicycle core's controller/datapath and a single-port synchronous word RAM. The RAM has one-cycle read latency and no byte enables. The unit accepts one load or store request at a time and checks alignment. Loads get byte/halfword extraction with sign or zero extension. Sub-word stores are done as read-modify-write. A single-cycle response pulse tells the controller's memory states the access is done.

Parameters:
ADDR_W, 32, byte-address width of req_addr and mem_addr.

Ports:
clk  in  1  clock
reset  in  1  async active-high reset
req_valid  in  1  request present; held stable by requester until accepted
req_ready  out  1  unit idle; request accepted when req_valid & req_ready at posedge
req_write  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I load/store funct3
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data (low bits used for sb/sh)
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_misaligned  out  1  valid with resp_valid; access rejected
mem_addr  out  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}
mem_we  out  1  RAM write strobe
mem_wdata  out  32  RAM write data
mem_rdata  in  32  RAM read data, valid the cycle after the address is presented with mem_we=0

Behaviour:
- Reset is asynchronous. It forces state IDLE and clears all registers: resp_valid, resp_misaligned, resp_rdata, mem_addr, mem_wdata are 0; mem_we is 0; req_ready is 1.
- Reset mid-operation aborts the access. mem_we falls immediately. The pending request is dropped and no response is issued.
- req_ready = (state==IDLE), combinational. mem_we = (state==WRITE), combinational from state.
- Accept: in IDLE with req_valid, latch write, funct3, addr, wdata. req_valid is ignored in every other state.
- Legal funct3:
  - Loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
  - Stores: 000 sb, 001 sh, 010 sw.
  - Anything else is illegal.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]≠0.
- States:
  - IDLE: accept request. Illegal or misaligned → ERR. Load → READ. sw → WRITE. sb/sh → READ.
  - READ: mem_addr = latched word address, mem_we=0 → RWAIT.
  - RWAIT: mem_rdata valid.
    - Load: register extracted data into resp_rdata → RESP.
    - Store: merge wdata into mem_rdata lane(s) selected by addr[1:0] into the mem_wdata register → WRITE.
  - WRITE: mem_we=1 for exactly one cycle. mem_wdata is the merged word, or req_wdata for sw → RESP.
  - RESP: resp_valid=1, resp_misaligned=0 → IDLE.
  - ERR: resp_valid=1, resp_misaligned=1, resp_rdata=0, no memory access → IDLE.
- Load extraction:
  - Byte = rdata[8*addr[1:0]+:8]; halfword = rdata[16*addr[1]+:16].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes through.
- Store merge:
  - sb replaces the byte lane addr[1:0] with wdata[7:0].
  - sh replaces the halfword lane addr[1] with wdata[15:0].
  - Other lanes keep the read value.
- Latency, counted from the accept edge to the resp_valid cycle:
  - Load: 3 cycles (READ, RWAIT, RESP).
  - sw: 2 cycles (WRITE, RESP).
  - sb/sh: 4 cycles.
  - Error: 1 cycle.
- The next request can be accepted in the cycle after RESP or ERR.
- resp_valid is never asserted outside RESP/ERR. There is no response backpressure.
- mem_addr holds its last value in IDLE.

Test Plan:
RAM[0x100]=0x8899AABB throughout unless written.
- lw 0x100 → resp_valid exactly 3 cycles after accept, resp_rdata=0x8899AABB, resp_misaligned=0, mem_we never high.
- lb 0x103 → 0xFFFFFF88. lbu 0x103 → 0x00000088. lh 0x102 → 0xFFFF8899. lhu 0x100 → 0x0000AABB.
- sb 0x101, wdata 0x12345677 → one mem_we cycle with mem_wdata=0x889977BB, resp 4 cycles after accept. A following lw 0x100 returns 0x889977BB.
- sh 0x101, lw 0x102, load funct3 011, store funct3 100 → each: resp_valid on the cycle after accept, resp_misaligned=1, resp_rdata=0, mem_we never high.
- Reset asserted during WRITE of sb 0x100 before the edge → mem_we drops immediately, RAM unchanged, no resp_valid, req_ready=1 after reset.
- req_valid held high continuously with back-to-back sw 0x104 then lw 0x104 → the second request is accepted only in the cycle after RESP, and lw returns the stored word.
